// File: rtl/quicksort_pkg.sv
// quicksort_pkg: shared widths, FSM state type and range-stack entry type
// for the iterative quicksort accelerator.
//   ELEM_W  - element width in bits
//   IDX_W   - index width in bits (covers up to 16 elements)
//   state_e - controller states
//   range_t - one (lo,hi) sub-range awaiting partitioning
package quicksort_pkg;

   localparam int ELEM_W = 4;
   localparam int IDX_W  = 4;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      SCAN,
      PUSH,
      DONE
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0] lo;
      logic [IDX_W-1:0] hi;
   } range_t;

endpackage

// File: rtl/quicksort_if.sv
// quicksort_if: request/result bundle between a controller and the sorter.
//   enable       - request level, held high for a whole job
//   array_in     - packed input elements, element 0 in the top nibble
//   lo_ind       - first index of the sort window (inclusive)
//   hi_ind       - last index of the sort window (inclusive)
//   array_valid  - result valid
//   sorted_array - packed result, same packing as array_in
interface quicksort_if import quicksort_pkg::*; #(
   parameter int ARR_WIDTH = 4
);

   logic                        enable;
   logic [ARR_WIDTH*ELEM_W-1:0] array_in;
   logic [IDX_W-1:0]            lo_ind;
   logic [IDX_W-1:0]            hi_ind;
   logic                        array_valid;
   logic [ARR_WIDTH*ELEM_W-1:0] sorted_array;

   modport master (
      output enable, array_in, lo_ind, hi_ind,
      input  array_valid, sorted_array
   );

   modport slave (
      input  enable, array_in, lo_ind, hi_ind,
      output array_valid, sorted_array
   );

endinterface

// File: rtl/quicksort_stack.sv
// quicksort_stack: register LIFO of (lo,hi) ranges.
//   clk, rst - clock, asynchronous active-high reset (empties the stack)
//   clear_i  - synchronous empty, used when a job is abandoned
//   push_i   - push data_i
//   pop_i    - discard the top entry (never together with push_i)
//   data_i   - entry to push
//   top_o    - current top entry (valid when !empty_o)
//   empty_o  - no entries held
module quicksort_stack import quicksort_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   clear_i,
   input  logic   push_i,
   input  logic   pop_i,
   input  range_t data_i,
   output range_t top_o,
   output logic   empty_o
);

   localparam int SPW = $clog2(DEPTH + 1);

   // Storage is rounded up to a power of two so the pointer indexes it directly.
   range_t          mem_q [2**SPW];
   logic [SPW-1:0]  sp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q <= '0;
      end else if (clear_i) begin
         sp_q <= '0;
      end else if (push_i) begin
         sp_q <= sp_q + 1'b1;
      end else if (pop_i) begin
         sp_q <= sp_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !clear_i) begin
         mem_q[sp_q] <= data_i;
      end
   end

   assign top_o   = mem_q[sp_q - 1'b1];
   assign empty_o = (sp_q == '0);

endmodule

// File: rtl/quicksort.sv
// quicksort: iterative Lomuto quicksort over the window lo_ind..hi_ind of a
// packed array of ARR_WIDTH 4-bit unsigned elements.
//   clock, reset - clock, asynchronous active-high reset
//   bus          - quicksort_if slave: enable/array_in/lo_ind/hi_ind in,
//                  array_valid/sorted_array out
module quicksort import quicksort_pkg::*; #(
   parameter int ARR_WIDTH = 4
) (
   input  logic      clock,
   input  logic      reset,
   quicksort_if.slave bus
);

   localparam int               AW    = $clog2(ARR_WIDTH);
   localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(ARR_WIDTH);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(ARR_WIDTH - 1);

   state_e                       state_q, state_d;
   logic [ELEM_W-1:0]            arr_q [ARR_WIDTH];
   logic [ELEM_W-1:0]            arr_d [ARR_WIDTH];
   logic [IDX_W-1:0]             lo_q, lo_d, hi_q, hi_d, i_q, i_d, j_q, j_d;
   logic [ELEM_W-1:0]            pivot_q, pivot_d;
   logic                         valid_q, valid_d;
   logic [ARR_WIDTH*ELEM_W-1:0]  sorted_q, sorted_d;

   logic   push, pop, clear, empty;
   range_t push_data, top;
   logic [IDX_W-1:0] hi_clamped;

   quicksort_stack #(.DEPTH(ARR_WIDTH)) u_stack (
      .clk     (clock),
      .rst     (reset),
      .clear_i (clear),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (push_data),
      .top_o   (top),
      .empty_o (empty)
   );

   assign hi_clamped = ({1'b0, bus.hi_ind} >= N_EXT) ? LAST : bus.hi_ind;

   always_comb begin
      state_d   = state_q;
      arr_d     = arr_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      i_d       = i_q;
      j_d       = j_q;
      pivot_d   = pivot_q;
      valid_d   = valid_q;
      sorted_d  = sorted_q;
      push      = 1'b0;
      pop       = 1'b0;
      clear     = 1'b0;
      push_data = '0;

      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (bus.enable) begin
               for (int unsigned k = 0; k < ARR_WIDTH; k++) begin
                  arr_d[AW'(k)] = bus.array_in[(ARR_WIDTH-k)*ELEM_W-1 -: ELEM_W];
               end
               push         = 1'b1;
               push_data.lo = bus.lo_ind;
               push_data.hi = hi_clamped;
               state_d      = POP;
            end
         end
         POP: begin
            if (empty) begin
               for (int unsigned k = 0; k < ARR_WIDTH; k++) begin
                  sorted_d[(ARR_WIDTH-k)*ELEM_W-1 -: ELEM_W] = arr_q[AW'(k)];
               end
               valid_d = 1'b1;
               state_d = DONE;
            end else begin
               pop = 1'b1;
               if (top.lo < top.hi) begin
                  lo_d    = top.lo;
                  hi_d    = top.hi;
                  i_d     = top.lo;
                  j_d     = top.lo;
                  pivot_d = arr_q[top.hi[AW-1:0]];
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (j_q < hi_q) begin
               if (arr_q[j_q[AW-1:0]] <= pivot_q) begin
                  arr_d[i_q[AW-1:0]] = arr_q[j_q[AW-1:0]];
                  arr_d[j_q[AW-1:0]] = arr_q[i_q[AW-1:0]];
                  i_d = i_q + 1'b1;
               end
               j_d = j_q + 1'b1;
            end else begin
               arr_d[i_q[AW-1:0]] = arr_q[hi_q[AW-1:0]];
               arr_d[hi_q[AW-1:0]] = arr_q[i_q[AW-1:0]];
               // The upper range (i+1,h) is pushed here, alongside the final
               // swap, so PUSH needs only one stack write for (l,i-1) and the
               // pair still lands in the same order.
               if (i_q < hi_q) begin
                  push         = 1'b1;
                  push_data.lo = i_q + 1'b1;
                  push_data.hi = hi_q;
               end
               state_d = PUSH;
            end
         end
         PUSH: begin
            if (i_q > lo_q) begin
               push         = 1'b1;
               push_data.lo = lo_q;
               push_data.hi = i_q - 1'b1;
            end
            state_d = POP;
         end
         DONE: begin
            if (!bus.enable) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Dropping enable mid-job abandons it: no result, stack emptied.
      if (!bus.enable && state_q != IDLE && state_q != DONE) begin
         state_d  = IDLE;
         clear    = 1'b1;
         push     = 1'b0;
         pop      = 1'b0;
         valid_d  = 1'b0;
         sorted_d = sorted_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         i_q      <= '0;
         j_q      <= '0;
         pivot_q  <= '0;
         valid_q  <= 1'b0;
         sorted_q <= '0;
         for (int unsigned k = 0; k < ARR_WIDTH; k++) begin
            arr_q[AW'(k)] <= '0;
         end
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         i_q      <= i_d;
         j_q      <= j_d;
         pivot_q  <= pivot_d;
         valid_q  <= valid_d;
         sorted_q <= sorted_d;
         arr_q    <= arr_d;
      end
   end

   assign bus.array_valid  = valid_q;
   assign bus.sorted_array = sorted_q;

endmodule

// File: tb/tb_quicksort.sv
// tb_quicksort: scoreboard bench for quicksort. Jobs queue their expected
// result (from a queue-sort reference model); a monitor pops and compares on
// each rising array_valid.
module tb_quicksort;

   localparam int N     = 4;
   localparam int W     = N * 4;
   localparam int BOUND = N * (N + 1) / 2 + 3 * N + 4;

   logic clock = 1'b0;
   logic reset;

   quicksort_if #(.ARR_WIDTH(N)) bus ();

   quicksort #(.ARR_WIDTH(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int unsigned     total  = 0;
   int unsigned     passed = 0;
   logic [W-1:0]    exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: pull the clamped window out, sort it, put it back.
   function automatic logic [W-1:0] ref_sort(input logic [W-1:0] a, input int lo, input int hi);
      logic [3:0]   el [N];
      logic [3:0]   win [$];
      logic [W-1:0] r;
      int           h;
      h = (hi >= N) ? N - 1 : hi;
      for (int k = 0; k < N; k++) el[k] = a[(N-k)*4-1 -: 4];
      if (lo < h) begin
         for (int k = lo; k <= h; k++) win.push_back(el[k]);
         win.sort();
         for (int k = lo; k <= h; k++) el[k] = win.pop_front();
      end
      r = '0;
      for (int k = 0; k < N; k++) r[(N-k)*4-1 -: 4] = el[k];
      return r;
   endfunction

   // Monitor
   initial begin
      logic prev;
      logic [W-1:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.array_valid && !prev) begin
            check("valid_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sorted", 64'(bus.sorted_array), 64'(e));
            end
         end
         prev = bus.array_valid;
      end
   end

   task automatic run_job(input logic [W-1:0] a, input int lo, input int hi);
      logic [W-1:0] e;
      logic         got;
      e = ref_sort(a, lo, hi);
      @(negedge clock);
      bus.array_in = a;
      bus.lo_ind   = lo[3:0];
      bus.hi_ind   = hi[3:0];
      bus.enable   = 1'b1;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      bus.array_in = W'($urandom);
      bus.lo_ind   = 4'($urandom);
      bus.hi_ind   = 4'($urandom);
      got = 1'b0;
      for (int n = 1; n <= BOUND; n++) begin
         @(posedge clock);
         #1;
         if (bus.array_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("latency_bound", 64'(got), 64'(1));
      if (!got) begin
         void'(exp_q.pop_back());
      end else begin
         @(posedge clock);
         #1;
         check("valid_held", 64'(bus.array_valid), 64'(1));
      end
      @(negedge clock);
      bus.enable = 1'b0;
      @(posedge clock);
      #1;
      check("valid_drop", 64'(bus.array_valid), 64'(0));
      check("result_kept", 64'(bus.sorted_array), 64'(e));
      repeat (2) @(posedge clock);
   endtask

   task automatic start_job(input logic [W-1:0] a);
      @(negedge clock);
      bus.array_in = a;
      bus.lo_ind   = 4'd0;
      bus.hi_ind   = 4'd3;
      bus.enable   = 1'b1;
      @(posedge clock);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a;
      int lo, hi;

      bus.enable   = 1'b0;
      bus.array_in = '0;
      bus.lo_ind   = '0;
      bus.hi_ind   = '0;
      reset        = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_valid", 64'(bus.array_valid), 64'(0));
      check("reset_data", 64'(bus.sorted_array), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("idle_valid", 64'(bus.array_valid), 64'(0));
      check("idle_data", 64'(bus.sorted_array), 64'(0));

      run_job(16'h3210, 0, 3);
      run_job(16'h5555, 0, 3);
      run_job(16'h7170, 0, 3);
      run_job(16'h7531, 1, 2);
      run_job(16'h7531, 2, 2);
      run_job(16'hA3F0, 0, 15);
      run_job(16'h4C2E, 3, 1);
      run_job(16'hF8E9, 1, 9);
      run_job(16'h0123, 0, 3);

      // Abort by dropping enable three cycles in.
      start_job(16'h3210);
      repeat (3) @(posedge clock);
      @(negedge clock);
      bus.enable = 1'b0;
      repeat (3) begin
         @(posedge clock);
         #1;
         check("abort_no_valid", 64'(bus.array_valid), 64'(0));
      end
      run_job(16'hB1D2, 0, 3);

      // Abort by asynchronous reset mid-sort.
      start_job(16'h9876);
      repeat (4) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("reset_async_valid", 64'(bus.array_valid), 64'(0));
      check("reset_async_data", 64'(bus.sorted_array), 64'(0));
      @(negedge clock);
      bus.enable = 1'b0;
      reset      = 1'b0;
      @(posedge clock);
      #1;
      check("post_reset_valid", 64'(bus.array_valid), 64'(0));
      run_job(16'h6F06, 0, 3);

      for (int t = 0; t < 500; t++) begin
         a = W'($urandom);
         if (t % 2 == 0) a = a & 16'h7777;
         if ($urandom_range(0, 1) == 0) begin
            lo = 0;
            hi = 3;
         end else begin
            lo = $urandom_range(0, 4);
            hi = $urandom_range(0, 15);
         end
         run_job(a, lo, hi);
      end

      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
